round_constant_gen: RTL and testbench
=====================================

# round_constant_gen

Sequential generator for the 32 Kuznyechik key-schedule round constants C_i = L(Vec128(i)), i = 1..32, feeding `round_constant` of the key schedule. Each constant is produced by applying the linear step R sixteen times, one per clock, using a 4-bit step counter. The generator then holds the constant under a valid/next handshake until the consumer advances it.

## Interface
- No parameters.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Level sampled each edge; starts or restarts generation at C_1.
- `next`  in  1  Consumer has taken the current constant; ignored while `const_valid`=0.
- `round_constant`  out  128  Current constant C_i, MSB = byte a15.
- `const_valid`  out  1  `round_constant` holds a finished C_i.
- `const_index`  out  6  i of the presented constant, 1..32.
- `counter`  out  4  R-step counter of the constant being computed, 0..15.
- `busy`  out  1  State is not IDLE or DONE.
- `done`  out  1  C_32 has been consumed; held until `start` or reset.

## Operation
- **Field arithmetic:** GF(2^8) with polynomial x^8+x^7+x^6+x+1 (0x1C3).
- **Linear functional:** l(a15..a0) = 148·a15 ⊕ 32·a14 ⊕ 133·a13 ⊕ 16·a12 ⊕ 194·a11 ⊕ 192·a10 ⊕ 1·a9 ⊕ 251·a8 ⊕ 1·a7 ⊕ 192·a6 ⊕ 194·a5 ⊕ 16·a4 ⊕ 133·a3 ⊕ 32·a2 ⊕ 148·a1 ⊕ 1·a0.
- **R step:** R(a15..a0) = l || a15..a1. The state shifts one byte toward the LSB and l enters at the MSB.
- **Input vector:** Vec128(i) = i zero-extended to 128 bits.
- **IDLE:** `start` loads `work` ← Vec128(1), `counter` ← 0, index ← 1, then goes to COMPUTE.
- **COMPUTE:** each edge, `work` ← R(`work`) and `counter`++.
  - On the edge with `counter`=15: `round_constant` ← R(`work`), `const_index` ← index, `const_valid` ← 1, state goes to PRESENT, `counter` ← 0.
- **PRESENT, `next`=1, index<32:** `const_valid` ← 0, `work` ← Vec128(index+1), index++, state goes to COMPUTE.
- **PRESENT, `next`=1, index=32:** `const_valid` ← 0, `done` ← 1, state goes to DONE. `const_index` holds 32 and `round_constant` holds C_32.
- **DONE:** waits for `start`.
- **`start` priority:** `start`=1 in any state restarts as from IDLE and clears `const_valid` and `done` on that edge. It overrides a simultaneous `next`.
- **Reset:** asserting `reset` (low) at any time clears all state immediately.
  - Outputs go to: `round_constant`=0, `const_valid`=0, `const_index`=0, `counter`=0, `busy`=0, `done`=0; state = IDLE.

## Timing
- **Start latency:** `start` sampled at edge S gives `const_valid`=1 after edge S+16.
- **Advance latency (macro off):** `next` sampled at edge E drops `const_valid` at E. The new constant is valid after E+16, so throughput is one constant per 17 cycles with `next` held high.
- **Stability:** `round_constant` and `const_index` change only on the edge that sets `const_valid`.
- **`counter` during PRESENT:** holds 0 (macro off).

## Configuration
- Macro: `RC_PREFETCH_EN`.
- **Defined:** a 128-bit shadow register and shadow-ready flag are added.
  - On entering PRESENT with index<32, computation of C_{index+1} starts immediately. Its 16 R steps are visible on `counter`, and the result goes to the shadow with shadow-ready ← 1.
  - `next` with shadow-ready=1 at edge E: `round_constant` ← shadow and index++ at E. `const_valid` stays 1, prefetch of the following constant starts, and there is no gap.
  - `next` with shadow-ready=0: `const_valid` ← 0. The constant is presented with `const_valid`=1 on the edge its computation completes.
  - `start` and reset clear shadow-ready.
- **Undefined:** no shadow register; behaviour is exactly as in Operation/Timing.

## Test plan
- Release reset, pulse `start` at edge 0 → `const_valid`=1 after edge 16; `round_constant`=6ea276726c487ab85d27bd10dd849401, `const_index`=1, `busy`=1.
- Pulse `next` while C_1 is presented → C_2 = dc87ece4d890f4b3ba4eb92079cbeb02, `const_index`=2.
  - Macro off: valid after 16 edges.
  - Macro on, with `next` issued ≥17 cycles after C_1 valid: valid continuously, updated at the `next` edge.
- Hold `next`=1 from `start` → 32 constants with `const_index` 1..32 in order; after C_32 is consumed, `done`=1, `busy`=0, `const_valid`=0, and `const_index` stays 32.
- Assert `reset` low while `counter`=7 in COMPUTE of C_3 → all outputs 0 immediately with no clock edge; after release, `start` yields C_1 with the same value and timing as scenario 1.
- `start` while presenting C_5 with `next`=1 on the same edge → `const_valid` drops; C_1 presented 16 edges later with `const_index`=1.
- `next` pulsed while `const_valid`=0 (mid-COMPUTE and in IDLE) → no change to index, `counter` sequence or outputs.

Source files
------------

// File: rtl/round_constant_gen.sv
// round_constant_gen: sequential generator of the 32 Kuznyechik key-schedule
// round constants C_i = L(Vec128(i)), i = 1..32, one R step per clock.
//
// Ports:
//   clk            in   1    rising-edge clock
//   reset          in   1    asynchronous active-low reset
//   start          in   1    start / restart generation at C_1 (overrides next)
//   next           in   1    consumer took the presented constant
//   round_constant out  128  presented constant C_i, MSB = byte a15
//   const_valid    out  1    round_constant holds a finished C_i
//   const_index    out  6    i of the presented constant (1..32)
//   counter        out  4    R-step counter of the constant being computed
//   busy           out  1    state is COMPUTE or PRESENT
//   done           out  1    C_32 consumed; held until start or reset
//
// Optional feature: define RC_PREFETCH_EN to add a shadow register that
// computes C_{i+1} while C_i is presented, so next can advance with no gap.
module round_constant_gen (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         next,
    output logic [127:0] round_constant,
    output logic         const_valid,
    output logic [5:0]   const_index,
    output logic [3:0]   counter,
    output logic         busy,
    output logic         done
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Coefficients of l, byte k multiplies input byte a_k (a15 in the top byte).
    localparam logic [127:0] L_COEF = 128'h94208510C2C001FB01C0C21085209401;

    logic [1:0]   state;
    logic [127:0] work;
    logic [5:0]   index;
    logic [127:0] r_work;
    logic         last;
`ifdef RC_PREFETCH_EN
    logic [127:0] shadow;
    logic         shadow_ready;
    logic         pf_active;
`endif

    // GF(2^8) multiply modulo x^8+x^7+x^6+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'd0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    // One R step: l enters at the MSB, the state shifts a byte toward the LSB.
    function automatic logic [127:0] r_step(input logic [127:0] a);
        logic [7:0] l;
        l = 8'd0;
        for (int k = 0; k < 16; k++)
            l = l ^ gf_mul(a[8*k +: 8], L_COEF[8*k +: 8]);
        return {l, a[127:8]};
    endfunction

    function automatic logic [127:0] vec(input logic [5:0] i);
        return {122'd0, i};
    endfunction

    assign r_work = r_step(work);
    assign last   = counter == 4'd15;
    assign busy   = state == COMPUTE || state == PRESENT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            work           <= '0;
            index          <= '0;
            counter        <= '0;
            round_constant <= '0;
            const_valid    <= 1'b0;
            const_index    <= '0;
            done           <= 1'b0;
`ifdef RC_PREFETCH_EN
            shadow         <= '0;
            shadow_ready   <= 1'b0;
            pf_active      <= 1'b0;
`endif
        end else if (start) begin
            state       <= COMPUTE;
            work        <= vec(6'd1);
            index       <= 6'd1;
            counter     <= '0;
            const_valid <= 1'b0;
            done        <= 1'b0;
`ifdef RC_PREFETCH_EN
            shadow_ready <= 1'b0;
            pf_active    <= 1'b0;
`endif
        end else begin
            case (state)
                COMPUTE: begin
                    // counter wraps to 0 on the sixteenth step by itself
                    work    <= r_work;
                    counter <= counter + 4'd1;
                    if (last) begin
                        round_constant <= r_work;
                        const_index    <= index;
                        const_valid    <= 1'b1;
                        state          <= PRESENT;
`ifdef RC_PREFETCH_EN
                        if (index != 6'd32) begin
                            work      <= vec(index + 6'd1);
                            index     <= index + 6'd1;
                            pf_active <= 1'b1;
                        end
`endif
                    end
                end
`ifdef RC_PREFETCH_EN
                PRESENT: begin
                    // index tracks the constant held in work / shadow, one
                    // ahead of const_index while a prefetch is in flight
                    if (pf_active) begin
                        work    <= r_work;
                        counter <= counter + 4'd1;
                        if (last) begin
                            shadow       <= r_work;
                            shadow_ready <= 1'b1;
                            pf_active    <= 1'b0;
                        end
                    end
                    if (next) begin
                        if (shadow_ready || (pf_active && last)) begin
                            // either the shadow is full or it fills on this very edge
                            round_constant <= shadow_ready ? shadow : r_work;
                            const_index    <= index;
                            shadow_ready   <= 1'b0;
                            pf_active      <= index != 6'd32;
                            if (index != 6'd32) begin
                                work  <= vec(index + 6'd1);
                                index <= index + 6'd1;
                            end
                        end else if (const_index == 6'd32) begin
                            const_valid <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            // prefetch still running: finish it in COMPUTE, which presents it
                            const_valid <= 1'b0;
                            pf_active   <= 1'b0;
                            state       <= COMPUTE;
                        end
                    end
                end
`else
                PRESENT: begin
                    if (next) begin
                        const_valid <= 1'b0;
                        if (index == 6'd32) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            work  <= vec(index + 6'd1);
                            index <= index + 6'd1;
                            state <= COMPUTE;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_round_constant_gen.sv
// tb_round_constant_gen: randomized scoreboard bench for round_constant_gen.
module tb_round_constant_gen;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         next;
    logic [127:0] round_constant;
    logic         const_valid;
    logic [5:0]   const_index;
    logic [3:0]   counter;
    logic         busy;
    logic         done;

    round_constant_gen dut (
        .clk(clk), .reset(reset), .start(start), .next(next),
        .round_constant(round_constant), .const_valid(const_valid),
        .const_index(const_index), .counter(counter), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [127:0] val;
        int           due;
    } exp_t;

    exp_t         q[$];
    logic [127:0] cref [1:32];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           pres_idx = 0;
    int           pres_due = 0;
    logic         live = 1'b0;
    logic         m_done = 1'b0;
    logic         pv = 1'b0;
    logic [5:0]   pi = '0;
    logic [127:0] prc = '0;
    logic         exp_valid;
    exp_t         e;

    always @(posedge clk) cyc <= cyc + 1;

    // carry-less product then polynomial long division by 0x1C3
    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'd0;
        for (int k = 0; k < 8; k++) if (b[k]) p = p ^ ({8'd0, a} << k);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h01C3 << (k - 8));
        return p[7:0];
    endfunction

    // L = sixteen R steps on a byte array, a[k] is byte a_k
    function automatic logic [127:0] lin(input logic [127:0] v);
        logic [7:0]   a  [16];
        logic [7:0]   cf [16];
        logic [7:0]   t;
        logic [127:0] res;
        cf = '{8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
               8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148};
        for (int k = 0; k < 16; k++) a[k] = v[8*k +: 8];
        for (int r = 0; r < 16; r++) begin
            t = 8'd0;
            for (int k = 0; k < 16; k++) t = t ^ fmul(a[k], cf[k]);
            for (int k = 0; k < 15; k++) a[k] = a[k+1];
            a[15] = t;
        end
        for (int k = 0; k < 16; k++) res[8*k +: 8] = a[k];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero();
        chk("rst_round_constant", round_constant, 128'd0);
        chk("rst_const_valid", 128'(const_valid), 128'd0);
        chk("rst_const_index", 128'(const_index), 128'd0);
        chk("rst_counter", 128'(counter), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
    endtask

    // drive one edge, then advance the reference model for that edge
    task automatic step(input logic s, input logic n);
        int nd;
        start = s;
        next  = n;
        @(posedge clk);
        #1;
        if (s) begin
            q.delete();
            live     = 1'b1;
            m_done   = 1'b0;
            pres_idx = 1;
            pres_due = cyc + 16;
            q.push_back('{1, cref[1], cyc + 16});
        end else if (n && live && pres_due < cyc) begin
            if (pres_idx == 32) begin
                live   = 1'b0;
                m_done = 1'b1;
            end else begin
`ifdef RC_PREFETCH_EN
                nd = (cyc > pres_due + 16) ? cyc : pres_due + 16;
`else
                nd = cyc + 16;
`endif
                pres_idx++;
                pres_due = nd;
                q.push_back('{pres_idx, cref[pres_idx], nd});
            end
        end
    endtask

    task automatic run_to_done(input int pct);
        int g;
        g = 0;
        while (!m_done && g < 4000) begin
            step(1'b0, $urandom_range(0, 99) < pct);
            g++;
        end
        chk("run_reached_done", 128'(m_done), 128'd1);
    endtask

    // monitor: pops the scoreboard whenever a new constant is presented
    always @(negedge clk) begin
        if (!reset) begin
            pv = 1'b0;
        end else begin
            exp_valid = live && pres_due <= cyc;
            chk("const_valid", 128'(const_valid), 128'(exp_valid));
            chk("busy", 128'(busy), 128'(live));
            chk("done", 128'(done), 128'(m_done));
`ifndef RC_PREFETCH_EN
            chk("counter", 128'(counter),
                128'((q.size() != 0 && q[0].due > cyc) ? 16 - (q[0].due - cyc) : 0));
`endif
            if (m_done) begin
                chk("final_index", 128'(const_index), 128'd32);
                chk("final_const", round_constant, cref[32]);
            end
            if (const_valid && (!pv || const_index != pi)) begin
                if (q.size() == 0) begin
                    chk("unexpected_present", 128'(const_index), 128'd0);
                end else begin
                    e = q.pop_front();
                    chk("present_index", 128'(const_index), 128'(e.idx));
                    chk("present_const", round_constant, e.val);
                    chk("present_cycle", 128'(cyc), 128'(e.due));
                end
            end else if (const_valid && pv) begin
                chk("stable_const", round_constant, prc);
            end
            if (q.size() != 0 && q[0].due < cyc) begin
                chk("late_present", 128'(cyc), 128'(q[0].due));
                q.delete(0);
            end
            pv  = const_valid;
            pi  = const_index;
            prc = round_constant;
        end
    end

    initial begin
        int g;
        reset = 1'b0;
        start = 1'b0;
        next  = 1'b0;
        for (int i = 1; i <= 32; i++) cref[i] = lin(128'(i));
        chk("ref_c1", cref[1], 128'h6ea276726c487ab85d27bd10dd849401);
        chk("ref_c2", cref[2], 128'hdc87ece4d890f4b3ba4eb92079cbeb02);
        #1;
        chk_zero();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        run_to_done(8);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        g = 0;
        while (!(live && pres_idx == 5 && pres_due <= cyc) && g < 2000) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            g++;
        end
        chk("reached_c5", 128'(pres_idx), 128'd5);
        step(1'b1, 1'b1);
        run_to_done(100);
        step(1'b1, 1'b0);
        g = 0;
        while (!(pres_idx == 3 && cyc == pres_due - 9) && g < 2000) begin
            step(1'b0, 1'b1);
            g++;
        end
        chk("mid_c3_counter", 128'(counter), 128'd7);
        #2;
        reset = 1'b0;
        #1;
        chk_zero();
        q.delete();
        live   = 1'b0;
        m_done = 1'b0;
        start  = 1'b0;
        next   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        run_to_done(30);
        start = 1'b0;
        next  = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
